// File: rtl/ppl_grid_stepper.sv
// Sequential grid stepper: ping-pong occupancy banks, one cell scanned per clock.
// Optional flood rules are compiled in when PPL_FLOOD_EN is defined.
module ppl_grid_stepper #(
  parameter int unsigned GRID_W     = 64,
  parameter int unsigned GRID_H     = 36,
  parameter int unsigned FOOD_W     = 7,
  parameter int unsigned FLOOD_ROWS = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int unsigned N  = GRID_W * GRID_H,
  localparam int unsigned AW = $clog2(N),
  localparam int unsigned PW = $clog2(N + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              step_in,
  input  logic [FOOD_W-1:0] food_in,
  input  logic              flood_in,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_cell,
  output logic              busy_out,
  output logic              done_out,
  output logic [PW-1:0]     pop_out
);

  localparam int unsigned XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int unsigned CW = (PW > FOOD_W) ? PW : FOOD_W;
  localparam int          FloodY = int'(GRID_H) - int'(FLOOD_ROWS);

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        cur_q, cur_d, nxt_q, nxt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [XW-1:0]       col_q, col_d;
  logic [YW-1:0]       row_q, row_d;
  logic [PW-1:0]       surv_q, surv_d, pop_q, pop_d;
  logic [FOOD_W-1:0]   food_q, food_d;
  logic                done_q, done_d;
  logic                rd_cell_q;
  logic                flood_lat;

  // Per-cell scratch for the scan decision.
  logic [AW-1:0]       tgt;
  logic [YW-1:0]       trow;
  logic                off_grid, blocked, dies;

`ifdef PPL_FLOOD_EN
  logic flood_q, flood_d;
  assign flood_lat = flood_q;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) flood_q <= 1'b0;
    else         flood_q <= flood_d;
  end
  always_comb begin
    flood_d = flood_q;
    if (state_q == StIdle && step_in) flood_d = flood_in;
  end
`else
  logic unused_flood;
  assign flood_lat    = 1'b0;
  assign unused_flood = flood_in ^ (FloodY > 0);
`endif

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    lfsr_d   = lfsr_q;
    idx_d    = idx_q;
    col_d    = col_q;
    row_d    = row_q;
    surv_d   = surv_q;
    food_d   = food_q;
    pop_d    = pop_q;
    done_d   = 1'b0;
    tgt      = idx_q;
    trow     = row_q;
    off_grid = 1'b0;
    blocked  = 1'b0;
    dies     = 1'b0;
    case (state_q)
      StIdle: begin
        // The write lands before the step so the scan sees the updated bank.
        if (wr_en && (int'(wr_addr) < int'(N))) begin
          cur_d[wr_addr] = wr_data;
          if (cur_q[wr_addr] != wr_data) pop_d = wr_data ? pop_q + PW'(1) : pop_q - PW'(1);
        end
        if (step_in) begin
          food_d  = food_in;
          nxt_d   = '0;
          idx_d   = '0;
          col_d   = '0;
          row_d   = '0;
          surv_d  = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        if (cur_q[idx_q]) begin
          case (lfsr_q[1:0])
            2'd0: begin
              off_grid = (row_q == '0);
              tgt      = idx_q - AW'(GRID_W);
              trow     = row_q - YW'(1);
            end
            2'd1: begin
              off_grid = (col_q == XW'(GRID_W - 1));
              tgt      = idx_q + AW'(1);
            end
            2'd2: begin
              off_grid = (row_q == YW'(GRID_H - 1));
              tgt      = idx_q + AW'(GRID_W);
              trow     = row_q + YW'(1);
            end
            default: begin
              off_grid = (col_q == '0);
              tgt      = idx_q - AW'(1);
            end
          endcase
          blocked = off_grid || cur_q[tgt] || nxt_q[tgt];
`ifdef PPL_FLOOD_EN
          dies    = flood_lat && (int'(row_q) >= FloodY);
          blocked = blocked || (flood_lat && (int'(trow) >= FloodY));
`endif
          dies = dies || (CW'(surv_q) == CW'(food_q));
          if (!dies) begin
            if (blocked) nxt_d[idx_q] = 1'b1;
            else         nxt_d[tgt]   = 1'b1;
            surv_d = surv_q + PW'(1);
          end
        end
        if (idx_q == AW'(N - 1)) begin
          state_d = StCommit;
        end else begin
          idx_d = idx_q + AW'(1);
          if (col_q == XW'(GRID_W - 1)) begin
            col_d = '0;
            row_d = row_q + YW'(1);
          end else begin
            col_d = col_q + XW'(1);
          end
        end
      end
      StCommit: begin
        cur_d   = nxt_q;
        pop_d   = surv_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      nxt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      idx_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      surv_q    <= '0;
      food_q    <= '0;
      pop_q     <= '0;
      done_q    <= 1'b0;
      rd_cell_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
      row_q     <= row_d;
      surv_q    <= surv_d;
      food_q    <= food_d;
      pop_q     <= pop_d;
      done_q    <= done_d;
      rd_cell_q <= (int'(rd_addr) < int'(N)) ? cur_q[rd_addr] : 1'b0;
    end
  end

  assign rd_cell  = rd_cell_q;
  assign busy_out = (state_q != StIdle);
  assign done_out = done_q;
  assign pop_out  = pop_q;

endmodule

// File: doc/ppl_grid_stepper.md
# ppl_grid_stepper

Parametrised, sequential successor to the Tiny World movement/collision logic. It holds a GRID_W×GRID_H occupancy grid in two ping-pong banks. On each step request it scans one cell per clock and applies random movement, collision blocking, a food cap and an optional flood kill. It then swaps banks and reports the new population. The display side reads cells through a registered read port instead of a flat 6912-bit bus.

## Interface
- GRID_W, default 64: grid columns.
- GRID_H, default 36: grid rows.
- FOOD_W, default 7: width of the food cap.
- FLOOD_ROWS, default 4: number of bottom rows killed by a flood.
- LFSR_SEED, default 16'hACE1: LFSR reset value; must be non-zero.
- N = GRID_W*GRID_H; AW = $clog2(N); PW = $clog2(N+1). These are derived localparams.
- clk_in, input, 1: system clock.
- rst_in, input, 1: asynchronous, active-low reset.
- step_in, input, 1: request one generation; sampled only in IDLE.
- food_in, input, FOOD_W: maximum survivors this step; latched with step_in.
- flood_in, input, 1: flood this step; latched with step_in.
- wr_en, input, 1: seed write into the current bank; honoured only in IDLE.
- wr_addr, input, AW: write cell index, y*GRID_W+x.
- wr_data, input, 1: write value (1 = occupied).
- rd_addr, input, AW: display read index.
- rd_cell, output, 1: current-bank cell at rd_addr, 1-cycle latency.
- busy_out, output, 1: high in SCAN and COMMIT.
- done_out, output, 1: one-cycle pulse when a step completes.
- pop_out, output, PW: population after the last completed step or write.

## Operation
- Banks are named cur and nxt, each N bits. A 16-bit Galois LFSR uses polynomial x^16+x^14+x^13+x^11+1. A scan index idx is AW bits wide. A survivor count surv is PW bits wide.
- IDLE behaviour:
  - wr_en writes cur[wr_addr].
  - pop_out is adjusted ±1 only when the written cell changes value.
  - step_in=1 latches food_in and flood_in, clears nxt, sets idx=0 and surv=0, and moves to SCAN.
  - When wr_en and step_in are both high, the write is applied first and the step uses the updated cur.
- SCAN processes cell idx on each edge, with the LFSR advancing once per edge:
  - cur[idx]=0 → no action.
  - Flood latched and row(idx) ≥ GRID_H−FLOOD_ROWS → the person dies.
  - Otherwise surv == food latched → the person dies.
  - Otherwise the person moves. Direction comes from lfsr[1:0]: 0 up (y−1), 1 right, 2 down, 3 left.
  - The target is blocked if it lies off-grid (no wrap), cur[target]=1, nxt[target]=1, or the flood is latched and the target is in a flooded row.
  - Blocked → set nxt[idx]. Not blocked → set nxt[target]. Either way, surv increments.
  - No person ever enters a cell occupied in cur, so nxt[idx] is always free when a person stays. The population only drops through food or flood.
  - idx==N−1 → COMMIT.
- COMMIT: cur⇐nxt, pop_out⇐surv, done_out⇐1, return to IDLE.
- While busy, step_in and wr_en are ignored. No request is queued.
- rd_cell always reads cur, so the display sees no partial generation.
- Arithmetic:
  - food is zero-extended to PW before comparison.
  - food ≥ N means no cap.
  - food=0 kills everyone.

## Timing
- Reset (rst_in low, asynchronous) clears the following:
  - cur and nxt both 0.
  - pop_out=0, rd_cell=0, busy_out=0, done_out=0.
  - LFSR=LFSR_SEED, state IDLE.
- Reset mid-step aborts the step with no done_out.
- The edge that samples step_in is edge 0. The following relative edges apply:
  - busy_out is high from edge 0 to edge N+1.
  - Edges 1..N process cells 0..N−1.
  - Edge N+1 performs the commit, raises done_out and pop_out, and drops busy_out.
  - done_out falls at edge N+2.
- A new step_in is accepted on edge N+2 at the earliest.
- rd_cell reflects rd_addr sampled at the previous edge. After the commit edge, rd_cell shows the new generation from the next read.

## Configuration
- PPL_FLOOD_EN defined: flood_in is latched and the flood rules above apply.
- PPL_FLOOD_EN undefined: flood_in is ignored, the flood latch is tied to 0, and no flood logic is synthesised. The port remains present.

## Test plan
All scenarios use GRID_W=4, GRID_H=4, FLOOD_ROWS=1.
- Reset: hold rst_in low, then release → pop_out=0, busy_out=0, done_out=0, and rd_cell=0 for addresses 0..15.
- Full grid: write all 16 cells, food_in=127, pulse step → every move is blocked; done_out pulses exactly 17 edges after the step edge; pop_out=16; all cells read 1.
- Food cap: write cells 0, 5, 10, 12, 15, food_in=3, pulse step → pop_out=3; cells 12 and 15 are absent from nxt; the total number of 1s read equals 3.
- Flood (PPL_FLOOD_EN): write cells 1 and 13, food_in=127, flood_in=1, pulse step → pop_out=1; cells 12..15 read 0. Without the macro the same stimulus gives pop_out=2.
- Busy lockout: pulse step, then assert step_in and wr_en to cell 7 during cycles 3..10 → exactly one done_out pulse; cell 7 is unchanged by the write.
- Reset mid-scan: drive rst_in low 5 edges after the step edge → busy_out=0 immediately, pop_out=0, no done_out, all cells read 0.
